pipeline_mdu: RTL and testbench



---
 rtl/pipeline_mdu.sv | 164 ++++++++++++++++
 tb/tb_pipeline_mdu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_mdu.sv
// Iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) with HI/LO result registers.
// Ports: clk, reset (sync, active-high), start/op/a/b request, flush cancel;
//        busy/done handshake, hi/lo results, div_by_zero flag.
// Optional macro MDU_RADIX4_EN: two iterations per cycle (latency WIDTH/2+1).
module pipeline_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef MDU_RADIX4_EN
    localparam int STEPS = 2;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH / 2);
`else
    localparam int STEPS = 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, next_state;

    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] mq_n;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] prod;

    assign accept = start && !flush && (state != RUN);
    assign last   = (cnt == CW'(1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // Signed ops iterate on magnitudes; signs are fixed up at commit.
    assign a_mag = (op[0] && a[WIDTH-1]) ? -a : a;
    assign b_mag = (op[0] && b[WIDTH-1]) ? -b : b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                next_state = IDLE;
                if (accept) begin
                    if (op[1] && (b == '0)) begin
                        next_state = DONE;
                    end else begin
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (last) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // One (or two) shift-add / restoring-divide iterations.
    // Multiply: {acc,mq} holds partial product and remaining multiplier bits.
    // Divide: acc is the partial remainder, mq shifts dividend out and quotient in.
    always_comb begin
        acc_n = acc;
        mq_n  = mq;
        sh    = '0;
        sum   = '0;
        for (int i = 0; i < STEPS; i++) begin
            if (is_div) begin
                sh = {acc_n, mq_n[WIDTH-1]};
                if (sh >= {1'b0, mcand}) begin
                    acc_n = WIDTH'(sh - {1'b0, mcand});
                    mq_n  = {mq_n[WIDTH-2:0], 1'b1};
                end else begin
                    acc_n = sh[WIDTH-1:0];
                    mq_n  = {mq_n[WIDTH-2:0], 1'b0};
                end
            end else begin
                sum   = {1'b0, acc_n} + (mq_n[0] ? {1'b0, mcand} : '0);
                mq_n  = {sum[0], mq_n[WIDTH-1:1]};
                acc_n = sum[WIDTH:1];
            end
        end
    end

    assign prod = neg_res ? -{acc_n, mq_n} : {acc_n, mq_n};

    always_ff @(posedge clk) begin
        if (reset) begin
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            mq          <= '0;
            mcand       <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            is_div      <= op[1];
            neg_res     <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem     <= op[0] & a[WIDTH-1];
            cnt         <= CNT_INIT;
            acc         <= '0;
            mq          <= op[1] ? a_mag : b_mag;
            mcand       <= op[1] ? b_mag : a_mag;
            div_by_zero <= 1'b0;
            if (op[1] && (b == '0)) begin
                hi          <= a;
                lo          <= '1;
                div_by_zero <= 1'b1;
            end
        end else if ((state == RUN) && !flush) begin
            acc <= acc_n;
            mq  <= mq_n;
            cnt <= cnt - CW'(1);
            if (last) begin
                if (is_div) begin
                    hi <= neg_rem ? -acc_n : acc_n;
                    lo <= neg_res ? -mq_n : mq_n;
                end else begin
                    hi <= prod[2*WIDTH-1:WIDTH];
                    lo <= prod[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_mdu.sv
// Directed self-checking bench for pipeline_mdu (WIDTH=32).
// Latency expectation follows MDU_RADIX4_EN when that macro is defined.
module tb_pipeline_mdu;

`ifdef MDU_RADIX4_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail = 0;

    pipeline_mdu #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .flush(flush),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Issues one op, scrambles inputs after the accept edge, optionally
    // pulses a stray start at RUN cycle 'poke', and waits for done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int poke,
                          output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = ~o; a = ~x; b = ~y;
        lat = -1;
        bcnt = 0;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == poke);
            if (c == poke) begin
                op = 2'b10; a = 32'd5; b = 32'd0;
            end
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_checks++;
        if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        n_checks++;
        if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    endtask

    task automatic test_multu();
        int lat, bc;
        run_op(2'b00, 32'hFFFFFFFF, 32'h00000002, 0, lat, bc);
        n_checks++;
        if (lat !== LAT + 1) begin n_fail++; $display("FAIL multu_latency: got %0d expected %0d", lat, LAT + 1); end
        n_checks++;
        if (bc !== LAT) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected %0d", bc, LAT); end
        n_checks++;
        if (hi !== 32'h00000001) begin n_fail++; $display("FAIL multu_hi: got %h expected 00000001", hi); end
        n_checks++;
        if (lo !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
        n_checks++;
        if (lo !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_lo_hold: got %h expected fffffffe", lo); end
        run_op(2'b00, 32'h12345678, 32'h00000010, 0, lat, bc);
        n_checks++;
        if ({hi, lo} !== 64'h0000000123456780) begin n_fail++; $display("FAIL multu_small: got %h%h expected 0000000123456780", hi, lo); end
    endtask

    task automatic test_mult_div();
        int lat, bc;
        run_op(2'b01, 32'hFFFFFFFD, 32'h00000007, 0, lat, bc);
        n_checks++;
        if ({hi, lo} !== 64'hFFFFFFFFFFFFFFEB) begin n_fail++; $display("FAIL mult_neg: got %h%h expected ffffffffffffffeb", hi, lo); end
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, bc);
        n_checks++;
        if ({hi, lo} !== 64'h0000000000000001) begin n_fail++; $display("FAIL mult_negneg: got %h%h expected 0000000000000001", hi, lo); end
        run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 0, lat, bc);
        n_checks++;
        if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_q: got %h expected fffffffd", lo); end
        n_checks++;
        if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg_r: got %h expected ffffffff", hi); end
        n_checks++;
        if (lat !== LAT + 1) begin n_fail++; $display("FAIL div_latency: got %0d expected %0d", lat, LAT + 1); end
        run_op(2'b11, 32'h00000007, 32'hFFFFFFFE, 0, lat, bc);
        n_checks++;
        if ({hi, lo} !== {32'h00000001, 32'hFFFFFFFD}) begin n_fail++; $display("FAIL div_negdivisor: got %h %h expected 00000001 fffffffd", hi, lo); end
        run_op(2'b10, 32'd100, 32'd7, 0, lat, bc);
        n_checks++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu: got %h %h expected 00000002 0000000e", hi, lo); end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        run_op(2'b10, 32'd5, 32'd0, 0, lat, bc);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
        n_checks++;
        if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
        n_checks++;
        if ({hi, lo} !== {32'h00000005, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL dbz_result: got %h %h expected 00000005 ffffffff", hi, lo); end
        run_op(2'b00, 32'h80000001, 32'h00000002, 0, lat, bc);
        n_checks++;
        if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_clear: got %b expected 0", div_by_zero); end
        n_checks++;
        if ({hi, lo} !== {32'h00000001, 32'h00000002}) begin n_fail++; $display("FAIL dbz_next_op: got %h %h expected 00000001 00000002", hi, lo); end
    endtask

    task automatic test_flush();
        int lat, bc, ndone;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        n_checks++;
        if (ndone !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d expected 0", ndone); end
        n_checks++;
        if ({hi, lo} !== {32'h00000001, 32'h00000002}) begin n_fail++; $display("FAIL flush_retain: got %h %h expected 00000001 00000002", hi, lo); end
        start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL start_flush_same: got busy=%b done=%b expected 0 0", busy, done); end
        run_op(2'b00, 32'd3, 32'd4, 5, lat, bc);
        n_checks++;
        if (lat !== LAT + 1) begin n_fail++; $display("FAIL ignored_start_latency: got %0d expected %0d", lat, LAT + 1); end
        n_checks++;
        if ({hi, lo, div_by_zero} !== {32'd0, 32'd12, 1'b0}) begin n_fail++; $display("FAIL ignored_start_result: got %h %h %b expected 00000000 0000000c 0", hi, lo, div_by_zero); end
    endtask

    task automatic test_min_div();
        int lat, bc;
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0, lat, bc);
        n_checks++;
        if (lo !== 32'h80000000) begin n_fail++; $display("FAIL min_div_lo: got %h expected 80000000", lo); end
        n_checks++;
        if (hi !== 32'h00000000) begin n_fail++; $display("FAIL min_div_hi: got %h expected 00000000", hi); end
        n_checks++;
        if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL min_div_dbz: got %b expected 0", div_by_zero); end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'h2;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL midreset_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
        n_checks++;
        if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL midreset_hilo: got %h %h expected 0 0", hi, lo); end
        run_op(2'b00, 32'hFFFFFFFF, 32'h00000002, 0, lat, bc);
        n_checks++;
        if (lat !== LAT + 1) begin n_fail++; $display("FAIL midreset_latency: got %0d expected %0d", lat, LAT + 1); end
        n_checks++;
        if ({hi, lo} !== {32'h00000001, 32'hFFFFFFFE}) begin n_fail++; $display("FAIL midreset_result: got %h %h expected 00000001 fffffffe", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_div();
        test_div_by_zero();
        test_flush();
        test_min_div();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
